// File: rtl/top_prod_accum_sat.sv
// Frame accumulator for the unsigned product stream: sums products until in_last,
// then rescales with round-half-up, saturates to OUT_WIDTH and holds the result for the writeback path.
module top_prod_accum_sat #(
    parameter int PROD_WIDTH = 92,
    parameter int ACC_WIDTH  = 100,
    parameter int OUT_WIDTH  = 64,
    parameter int FRAC_SHIFT = 28,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ACC_WIDTH-1:0] acc_reg;
    logic                 ovf_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [OUT_WIDTH-1:0] out_data_reg;
    logic                 out_sat_reg;
    logic [CNT_WIDTH-1:0] out_count_reg;
    logic                 out_valid_reg;

    logic                 beat_fire;
    logic                 out_fire;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH:0]   round_bias;
    logic [ACC_WIDTH:0]   rounded;
    logic [ACC_WIDTH:0]   rounded_hi;
    logic                 round_sat;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign beat_fire = in_valid & in_ready;
    assign out_fire  = out_valid_reg & out_ready;

    // One extra bit so the carry out of the accumulator is visible for the sticky overflow.
    assign acc_sum = {1'b0, acc_reg} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_data};

    assign round_bias = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    assign rounded    = ({1'b0, acc_reg} + round_bias) >> FRAC_SHIFT;
    assign rounded_hi = rounded >> OUT_WIDTH;
    assign round_sat  = ovf_reg | (|rounded_hi);

    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready is a pure state decode so it never depends on in_valid.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (beat_fire) begin
                        acc_reg <= acc_sum[ACC_WIDTH-1:0];
                        ovf_reg <= ovf_reg | acc_sum[ACC_WIDTH];
                        cnt_reg <= cnt_inc;
                    end
                end
                ROUND: begin
                    if (round_sat) begin
                        out_data_reg <= '1;
                        out_sat_reg  <= 1'b1;
                    end else begin
                        out_data_reg <= rounded[OUT_WIDTH-1:0];
                        out_sat_reg  <= 1'b0;
                    end
                    out_count_reg <= cnt_reg;
                    out_valid_reg <= 1'b1;
                end
                OUT: begin
                    // Result fields stay as they are after the handshake; only valid drops.
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        ovf_reg       <= 1'b0;
                        cnt_reg       <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_count = out_count_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_top_prod_accum_sat.sv
// Directed bench for top_prod_accum_sat: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_top_prod_accum_sat;

    localparam int PW = 92;
    localparam int OW = 64;
    localparam int CW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [PW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] stim[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    top_prod_accum_sat dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [PW-1:0] fx(input int v);
        logic [PW-1:0] t;
        t = PW'(v);
        return t << 28;
    endfunction

    task automatic push_exp(input logic [OW-1:0] d, input logic s, input logic [CW-1:0] c);
        exp_t e;
        e.d = d;
        e.s = s;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_beat(input logic [PW-1:0] d, input logic last);
        int n;
        n = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge ap_clk);
        while (!in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the beats in stim as one frame and checks the result timing around it.
    task automatic run_frame(input logic [OW-1:0] d, input logic s, input logic [CW-1:0] c);
        push_exp(d, s, c);
        for (int i = 0; i < stim.size(); i++) begin
            send_beat(stim[i], (i == stim.size() - 1));
        end
        stim.delete();
        check("round_valid_low", out_valid, 0);
        check("round_ready_low", in_ready, 0);
        @(posedge ap_clk);
        #1;
        check("valid_after_E1", out_valid, 1);
        check("out_ready_low", in_ready, 0);
        if (out_ready) begin
            @(posedge ap_clk);
            #1;
            check("ready_after_F", in_ready, 1);
            check("valid_drop_after_F", out_valid, 0);
        end
    endtask

    // Monitor: one pop per output handshake.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (!ap_rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.d);
                    check("sb_sat", out_sat, e.s);
                    check("sb_count", out_count, e.c);
                end
            end
        end
    end

    initial begin
        int n;
        ap_rst    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // Basic and rounding boundaries
        stim.push_back(fx(3));
        run_frame(64'd3, 1'b0, 16'd1);
        stim.push_back(PW'(1) << 27);
        run_frame(64'd1, 1'b0, 16'd1);
        stim.push_back((PW'(1) << 27) - PW'(1));
        run_frame(64'd0, 1'b0, 16'd1);
        stim.push_back(fx(5));
        stim.push_back(PW'(1) << 27);
        run_frame(64'd6, 1'b0, 16'd2);

        // Saturation on the rounded value, and the largest value that just fits
        stim.push_back({PW{1'b1}});
        run_frame({OW{1'b1}}, 1'b1, 16'd1);
        stim.push_back({{OW{1'b1}}, 28'h0});
        run_frame({OW{1'b1}}, 1'b0, 16'd1);

        // Accumulator overflow on beat 257, then the sticky flag must be cleared
        for (int i = 0; i < 257; i++) stim.push_back({PW{1'b1}});
        run_frame({OW{1'b1}}, 1'b1, 16'd257);
        stim.push_back(fx(1));
        run_frame(64'd1, 1'b0, 16'd1);

        // Backpressure: result held, no beats absorbed
        out_ready = 1'b0;
        stim.push_back(fx(2));
        run_frame(64'd2, 1'b0, 16'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = fx(100 + i);
            @(negedge ap_clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 64'd2);
            check("bp_out_count", out_count, 16'd1);
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_ready", in_ready, 1);
        stim.push_back(fx(4));
        run_frame(64'd4, 1'b0, 16'd1);

        // Reset after 3 of 4 beats
        for (int i = 0; i < 3; i++) send_beat(fx(9), 1'b0);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_out_data", out_data, 0);
        check("midrst_out_count", out_count, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        stim.push_back(fx(7));
        run_frame(64'd7, 1'b0, 16'd1);

        // Reset while a result is pending drops out_valid at once and discards it
        out_ready = 1'b0;
        stim.push_back(fx(9));
        run_frame(64'd9, 1'b0, 16'd1);
        #2;
        ap_rst = 1'b1;
        #1;
        check("outrst_out_valid", out_valid, 0);
        check("outrst_out_data", out_data, 0);
        void'(exp_q.pop_back());
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        stim.push_back(fx(11));
        run_frame(64'd11, 1'b0, 16'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge ap_clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_prod_accum_sat.md
Name: top_prod_accum_sat

Overview:
- Downstream consumer of the unsigned 28x64->92-bit product stage. Accepts a stream of 92-bit unsigned products over a valid/ready handshake and sums each frame, delimited by `in_last`, in a wide accumulator.
- At frame end it rescales the sum by a fixed-point right shift with round-half-up, saturates to 64 bits, and presents the result on a valid/ready output.
- Sits between the multiplier and the result writeback path.

Parameters:
- PROD_WIDTH, 92, width of incoming unsigned product.
- ACC_WIDTH, 100, accumulator width; no overflow for up to 2^(ACC_WIDTH-PROD_WIDTH) = 256 max-value products.
- OUT_WIDTH, 64, width of the rescaled result.
- FRAC_SHIFT, 28, fractional bits removed by rescale; must be >= 1.
- CNT_WIDTH, 16, width of the beat counter.

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_data  in  PROD_WIDTH  unsigned product.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final beat of frame; qualified by in_valid.
- in_ready  out  1  block accepts a beat.
- out_data  out  OUT_WIDTH  rounded, saturated frame result.
- out_sat  out  1  out_data was clamped.
- out_count  out  CNT_WIDTH  beats in frame, saturating.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; acc=0, ovf=0, cnt=0; out_data=0, out_sat=0, out_count=0, out_valid=0. in_ready=0 while in reset.
- in_ready is a decode of state (1 only in ACC); it is not a function of in_valid.
- FSM:
  - IDLE -> ACC unconditionally on the next edge.
  - ACC: a beat is accepted on an edge where in_valid & in_ready.
    - acc <= acc + zero-extended in_data, mod 2^ACC_WIDTH.
    - Carry out of ACC_WIDTH sets sticky ovf.
    - cnt <= cnt+1, holding at 2^CNT_WIDTH-1.
    - If in_last, go to ROUND. Otherwise stay in ACC.
  - ROUND (exactly 1 cycle, in_ready=0): compute r = (acc + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT at ACC_WIDTH+1 bits.
    - If ovf=1 or r >= 2^OUT_WIDTH: out_data <= all ones, out_sat <= 1.
    - Else: out_data <= r[OUT_WIDTH-1:0], out_sat <= 0.
    - out_count <= cnt; out_valid <= 1; go to OUT.
  - OUT: out_valid=1 and out_data/out_sat/out_count are held stable until out_ready.
    - On an edge with out_ready: out_valid <= 0, acc <= 0, ovf <= 0, cnt <= 0, go to ACC.
    - in_ready=0 throughout OUT.
- Latency: last beat accepted at edge E -> out_valid=1 after edge E+1. Result handshake at edge F -> in_ready=1 after edge F.
- Throughput: at least 2 cycles of in_ready=0 between frames; one beat per cycle within a frame.
- A frame always contains at least one beat; a single beat with in_last=1 is a complete frame.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- Reset asserted mid-frame or during OUT discards the partial sum and any pending result; out_valid drops immediately (asynchronous).
- out_data, out_sat and out_count are retained after the out handshake until the next ROUND; they are meaningful only while out_valid=1.

Test Plan:
- Single beat in_data=3<<28 with in_last=1 -> out_data=3, out_sat=0, out_count=1; out_valid rises one edge after acceptance.
- Rounding boundary:
  - Frame of one beat 2^27 -> out_data=1.
  - Frame of one beat 2^27-1 -> out_data=0.
  - Frame of beats 5<<28 and 2^27 -> out_data=6, out_count=2.
- Saturation:
  - One beat of 2^92-1 -> r=2^64 -> out_data=0xFFFF_FFFF_FFFF_FFFF, out_sat=1.
  - One beat of (2^64-1)<<28 -> out_data=0xFFFF_FFFF_FFFF_FFFF, out_sat=0.
- Accumulator overflow:
  - 257 beats of 2^92-1 -> ovf set -> out_sat=1, out_count=257.
  - Next frame, one beat 1<<28 -> out_data=1, out_sat=0 (ovf cleared).
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 with changing data -> in_ready=0, out_* stable, no beats absorbed. Raise out_ready -> next frame accumulates from 0.
- Reset mid-frame:
  - Assert ap_rst after 3 of 4 beats -> all outputs 0 immediately.
  - After release, frame of one beat 7<<28 -> out_data=7, out_count=1.
